// File: rtl/alu_seq_stage.sv
// -----------------------------------------------------------------------------
// alu_seq_stage
//   Sequencing ALU stage that feeds the output load register. An operand pair
//   and opcode are captured on a start request. Single-cycle ops (add, sub,
//   logic, shifts) produce their result one cycle later. Iterative ops
//   (shift-add multiply and, optionally, restoring divide/modulo) run N
//   iterations on a 2N-bit accumulator and produce their result N+1 cycles
//   after the request. Every result is presented with C/N/V/Z flags, a hex
//   7-segment pattern and a one-cycle valid strobe.
//
// Configuration:
//   ALU_DIVMOD_EN  defined   : opcodes 8 (DIV) and 9 (MOD) use the iterative
//                              restoring divider.
//                  undefined : no divider is built; opcodes 8/9 are illegal.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, accepted in IDLE or DONE only
//   opcode[3:0]     0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 MUL,8 DIV,9 MOD
//   a, b [N-1:0]    operands
//   busy            operation in flight
//   valid           one-cycle strobe, outputs hold a new result
//   result[N-1:0]   registered result
//   outFlagC_m/N/V/Z registered flags
//   segA_m[6:0]     active-low {g,f,e,d,c,b,a} pattern for result[3:0]
// -----------------------------------------------------------------------------
module alu_seq_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   opcode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] result,
    output logic         outFlagC_m,
    output logic         outFlagN_m,
    output logic         outFlagV_m,
    output logic         outFlagZ_m,
    output logic [6:0]   segA_m
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
`ifdef ALU_DIVMOD_EN
    localparam logic [3:0] OP_DIV = 4'd8;
    localparam logic [3:0] OP_MOD = 4'd9;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [N-1:0]    opA_r;
    logic [N-1:0]    opB_r;
    logic [3:0]      opc_r;
    logic [CW-1:0]   iterCnt_r;
    logic [2*N-1:0]  acc_r;

    logic [2*N-1:0]  accInit_s;
    logic [2*N-1:0]  accNext_s;
    logic [N-1:0]    execRes_s;
    logic            execC_s;
    logic            execV_s;
    logic [N-1:0]    iterRes_s;
    logic            iterC_s;
    logic            iterV_s;
    logic [N-1:0]    finRes_s;
    logic            finC_s;
    logic            finV_s;

    // Active-low hex digit pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Opcodes that take the N-iteration path.
    function automatic logic isIter(input logic [3:0] op);
        logic r;
        case (op)
            OP_MUL:  r = 1'b1;
`ifdef ALU_DIVMOD_EN
            OP_DIV,
            OP_MOD:  r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Accumulator seed: multiplier in the low half for MUL, dividend for DIV/MOD.
    always_comb begin
        accInit_s = {(2*N){1'b0}};
        case (opcode)
            OP_MUL:  accInit_s = {{N{1'b0}}, b};
`ifdef ALU_DIVMOD_EN
            OP_DIV,
            OP_MOD:  accInit_s = {{N{1'b0}}, a};
`endif
            default: accInit_s = {(2*N){1'b0}};
        endcase
    end

    // One iteration step of the multiplier / restoring divider.
    always_comb begin
        logic [N:0] mulHi;
        logic [N:0] divTmp;
        logic [N:0] divTrial;
        mulHi     = {(N+1){1'b0}};
        divTmp    = {(N+1){1'b0}};
        divTrial  = {(N+1){1'b0}};
        accNext_s = acc_r;
        case (opc_r)
            // Add the multiplicand into the high half when the current
            // multiplier bit is set, then shift the whole pair right.
            OP_MUL: begin
                mulHi     = {1'b0, acc_r[2*N-1:N]}
                          + (acc_r[0] ? {1'b0, opA_r} : {(N+1){1'b0}});
                accNext_s = {mulHi, acc_r[N-1:1]};
            end
`ifdef ALU_DIVMOD_EN
            // High half holds the partial remainder, low half the dividend
            // shifting out while quotient bits shift in. Bit N of the trial
            // difference is the borrow: clear means the subtraction stands.
            OP_DIV,
            OP_MOD: begin
                divTmp   = {acc_r[2*N-1:N], acc_r[N-1]};
                divTrial = divTmp - {1'b0, opB_r};
                if (!divTrial[N]) begin
                    accNext_s = {divTrial[N-1:0], acc_r[N-2:0], 1'b1};
                end else begin
                    accNext_s = {divTmp[N-1:0], acc_r[N-2:0], 1'b0};
                end
            end
`endif
            default: accNext_s = acc_r;
        endcase
    end

    // Single-cycle datapath on the captured operands.
    always_comb begin
        logic [N:0]     sum;
        logic [2*N-1:0] wide;
        sum       = {(N+1){1'b0}};
        wide      = {(2*N){1'b0}};
        execRes_s = {N{1'b0}};
        execC_s   = 1'b0;
        execV_s   = 1'b0;
        case (opc_r)
            OP_ADD: begin
                sum       = {1'b0, opA_r} + {1'b0, opB_r};
                execRes_s = sum[N-1:0];
                execC_s   = sum[N];
                execV_s   = (opA_r[N-1] == opB_r[N-1]) && (sum[N-1] != opA_r[N-1]);
            end
            OP_SUB: begin
                sum       = {1'b0, opA_r} + {1'b0, ~opB_r} + {{N{1'b0}}, 1'b1};
                execRes_s = sum[N-1:0];
                execC_s   = sum[N];
                execV_s   = (opA_r[N-1] != opB_r[N-1]) && (sum[N-1] != opA_r[N-1]);
            end
            OP_AND: execRes_s = opA_r & opB_r;
            OP_OR:  execRes_s = opA_r | opB_r;
            OP_XOR: execRes_s = opA_r ^ opB_r;
            // Shifting inside a 2N-bit window leaves the last bit shifted out
            // at bit N (left) or bit N-1 (right); it is zero for s=0.
            OP_SHL: begin
                wide      = {{N{1'b0}}, opA_r} << opB_r[SW-1:0];
                execRes_s = wide[N-1:0];
                execC_s   = wide[N];
            end
            OP_SHR: begin
                wide      = {opA_r, {N{1'b0}}} >> opB_r[SW-1:0];
                execRes_s = wide[2*N-1:N];
                execC_s   = wide[N-1];
            end
            default: begin
                execRes_s = {N{1'b0}};
                execC_s   = 1'b0;
                execV_s   = 1'b0;
            end
        endcase
    end

    // Result extraction once all iterations have completed.
    always_comb begin
        iterRes_s = {N{1'b0}};
        iterC_s   = 1'b0;
        iterV_s   = 1'b0;
        case (opc_r)
            OP_MUL: begin
                iterRes_s = acc_r[N-1:0];
                iterC_s   = |acc_r[2*N-1:N];
            end
`ifdef ALU_DIVMOD_EN
            OP_DIV,
            OP_MOD: begin
                if (opB_r == {N{1'b0}}) begin
                    iterRes_s = {N{1'b1}};
                    iterV_s   = 1'b1;
                end else if (opc_r == OP_DIV) begin
                    iterRes_s = acc_r[N-1:0];
                end else begin
                    iterRes_s = acc_r[2*N-1:N];
                end
            end
`endif
            default: begin
                iterRes_s = {N{1'b0}};
                iterC_s   = 1'b0;
                iterV_s   = 1'b0;
            end
        endcase
    end

    // Select which datapath drives the output register this cycle.
    always_comb begin
        if (state_r == ITER) begin
            finRes_s = iterRes_s;
            finC_s   = iterC_s;
            finV_s   = iterV_s;
        end else begin
            finRes_s = execRes_s;
            finC_s   = execC_s;
            finV_s   = execV_s;
        end
    end

    // Sequencer FSM with operand capture, iteration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            opA_r      <= {N{1'b0}};
            opB_r      <= {N{1'b0}};
            opc_r      <= 4'd0;
            iterCnt_r  <= {CW{1'b0}};
            acc_r      <= {(2*N){1'b0}};
            busy       <= 1'b0;
            valid      <= 1'b0;
            result     <= {N{1'b0}};
            outFlagC_m <= 1'b0;
            outFlagN_m <= 1'b0;
            outFlagV_m <= 1'b0;
            outFlagZ_m <= 1'b0;
            segA_m     <= 7'b1111111;
        end else begin
            case (state_r)
                // DONE accepts a new request exactly like IDLE.
                IDLE, DONE: begin
                    valid <= 1'b0;
                    if (start) begin
                        opA_r     <= a;
                        opB_r     <= b;
                        opc_r     <= opcode;
                        acc_r     <= accInit_s;
                        iterCnt_r <= {CW{1'b0}};
                        busy      <= 1'b1;
                        state_r   <= isIter(opcode) ? ITER : EXEC;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                EXEC: begin
                    result     <= finRes_s;
                    outFlagC_m <= finC_s;
                    outFlagN_m <= finRes_s[N-1];
                    outFlagV_m <= finV_s;
                    outFlagZ_m <= (finRes_s == {N{1'b0}});
                    segA_m     <= hex7(finRes_s[3:0]);
                    valid      <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= DONE;
                end
                // N iteration edges, then one edge to register the result.
                ITER: begin
                    if (iterCnt_r == CW'(N)) begin
                        result     <= finRes_s;
                        outFlagC_m <= finC_s;
                        outFlagN_m <= finRes_s[N-1];
                        outFlagV_m <= finV_s;
                        outFlagZ_m <= (finRes_s == {N{1'b0}});
                        segA_m     <= hex7(finRes_s[3:0]);
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= DONE;
                    end else begin
                        acc_r     <= accNext_s;
                        iterCnt_r <= iterCnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
